seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's eight-digit common-anode seven-segment display. It captures a 32-bit hex word and cycles one digit at a time through the nibble-to-segment decoder. Each digit slot is followed by an all-off dead time to suppress ghosting. Writes are double-buffered so a new value only takes effect at a frame boundary and the display never tears.

---
 rtl/seg7_scan_if.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 75 +++++++
 tb/tb_seg7_scan_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: host-side value/control inputs and display-side outputs of the scan controller
interface seg7_scan_if;
  logic [31:0] data;
  logic        load;
  logic [7:0]  en_mask;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic [7:0]  an;
  logic [6:0]  a2g;
  logic        dp;
  logic        frame_done;
  modport master (output data, load, en_mask, dp_mask, blank_lz, input an, a2g, dp, frame_done);
  modport slave  (input data, load, en_mask, dp_mask, blank_lz, output an, a2g, dp, frame_done);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: eight-digit multiplexed seven-segment scanner with dead time and frame-synchronous double buffering
module seg7_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  seg7_scan_if.slave  bus
);
  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic {SHOW, BLANK} state_t;
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] staged_q, staged_d, shown_q, shown_d;
  logic        pending_q, pending_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  a2g_q, a2g_d;
  logic        dp_q, dp_d, frame_done_q, frame_done_d;
  logic        show_end, blank_end, boundary, lz, lit;
  logic [3:0]  nib;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SHOW;
      cnt_q        <= '0;
      idx_q        <= '0;
      staged_q     <= '0;
      shown_q      <= '0;
      pending_q    <= 1'b0;
      an_q         <= 8'hFF;
      a2g_q        <= 7'h7F;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staged_q     <= staged_d;
      shown_q      <= shown_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      a2g_q        <= a2g_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end
  assign show_end  = state_q == SHOW  && cnt_q == CW'(SCAN_DIV - 1);
  assign blank_end = state_q == BLANK && cnt_q == CW'(BLANK_CYC - 1);
  assign boundary  = blank_end && idx_q == 3'd7;
  always_comb begin
    state_d   = show_end ? BLANK : blank_end ? SHOW : state_q;
    cnt_d     = (show_end || blank_end) ? '0 : cnt_q + 1'b1;
    idx_d     = blank_end ? idx_q + 3'd1 : idx_q;
    staged_d  = bus.load ? bus.data : staged_q;
    pending_d = bus.load ? 1'b1 : boundary ? 1'b0 : pending_q;
    // commit uses the pre-load staged value even when a load lands on the boundary
    shown_d   = (boundary && pending_q) ? staged_q : shown_q;
  end
  always_comb begin
    nib          = shown_q[{idx_q, 2'b00} +: 4];
    lz           = bus.blank_lz && idx_q != 3'd0 && (shown_q >> {idx_q, 2'b00}) == 32'd0;
    lit          = state_q == SHOW && bus.en_mask[idx_q] && !lz;
    an_d         = lit ? ~(8'd1 << idx_q) : 8'hFF;
    a2g_d        = lit ? SEG[nib] : 7'h7F;
    dp_d         = lit ? ~bus.dp_mask[idx_q] : 1'b1;
    frame_done_d = boundary;
  end
  assign bus.an         = an_q;
  assign bus.a2g        = a2g_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of scan order, decode, buffering, blanking, masks and reset
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   e = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  seg7_scan_if bus ();
  seg7_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction
  function automatic logic [15:0] exp_out(input int ec, input logic [31:0] sh, input logic [7:0] en,
                                          input logic [7:0] dpm, input logic blz);
    int p, k, s;
    logic lit, zero_lead;
    p = (ec - 1) % 48;
    k = p / 6;
    s = p % 6;
    zero_lead = blz && k != 0 && (sh >> (4 * k)) == 32'd0;
    lit = s < 4 && en[k] && !zero_lead;
    if (!lit) return {8'hFF, 7'h7F, 1'b1};
    return {~(8'h01 << k), seg_of(sh[4*k +: 4]), ~dpm[k]};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
  endtask
  task automatic test_reset();
    logic [15:0] ex;
    bus.en_mask = 8'hFF; bus.dp_mask = 8'h00; bus.blank_lz = 1'b0; bus.load = 1'b0; bus.data = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.an, bus.a2g, bus.dp, bus.frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got an=%h a2g=%h dp=%b fd=%b, want FF 7F 1 0", bus.an, bus.a2g, bus.dp, bus.frame_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    step();
    n_chk++;
    if ({bus.an, bus.a2g, bus.dp} !== {8'hFE, 7'h40, 1'b1}) begin
      n_fail++;
      $display("FAIL first_edge: got an=%h a2g=%h dp=%b, want FE 40 1", bus.an, bus.a2g, bus.dp);
    end
    for (int i = 2; i <= 48; i++) begin
      step();
      ex = exp_out(e, 32'h0, 8'hFF, 8'h00, 1'b0);
      n_chk++;
      if ({bus.an, bus.a2g, bus.dp} !== ex || bus.frame_done !== (e == 48)) begin
        n_fail++;
        $display("FAIL scan_frame1 e=%0d: got %h/%b, want %h/%b", e, {bus.an, bus.a2g, bus.dp}, bus.frame_done, ex, e == 48);
      end
    end
  endtask
  task automatic test_load();
    logic [6:0] want [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
    logic [15:0] ex;
    do_reset();
    while (e < 10) step();
    bus.data = 32'h89ABCDEF; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    while (e < 48) begin
      step();
      ex = exp_out(e, 32'h0, 8'hFF, 8'h00, 1'b0);
      n_chk++;
      if ({bus.an, bus.a2g, bus.dp} !== ex) begin
        n_fail++;
        $display("FAIL load_not_early e=%0d: got %h, want %h", e, {bus.an, bus.a2g, bus.dp}, ex);
      end
    end
    while (e < 96) begin
      step();
      if ((e - 49) % 6 < 4) begin
        n_chk++;
        if (bus.a2g !== want[(e - 49) / 6] || bus.an !== ~(8'h01 << ((e - 49) / 6))) begin
          n_fail++;
          $display("FAIL load_shown e=%0d: got an=%h a2g=%h, want an=%h a2g=%h", e, bus.an, bus.a2g, ~(8'h01 << ((e - 49) / 6)), want[(e - 49) / 6]);
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] ex;
    do_reset();
    while (e < 5) step();
    bus.data = 32'h11111111; bus.load = 1'b1; step(); bus.load = 1'b0;
    while (e < 20) step();
    bus.data = 32'h22222222; bus.load = 1'b1; step(); bus.load = 1'b0;
    while (e < 47) step();
    bus.data = 32'h33333333; bus.load = 1'b1; step(); bus.load = 1'b0;
    n_chk++;
    if (bus.frame_done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_frame_done: got %b, want 1", bus.frame_done);
    end
    while (e < 144) begin
      step();
      ex = exp_out(e, (e <= 96) ? 32'h22222222 : 32'h33333333, 8'hFF, 8'h00, 1'b0);
      n_chk++;
      if ({bus.an, bus.a2g, bus.dp} !== ex) begin
        n_fail++;
        $display("FAIL b2b_shown e=%0d: got %h, want %h", e, {bus.an, bus.a2g, bus.dp}, ex);
      end
    end
  endtask
  task automatic test_leading_zero();
    logic [15:0] ex;
    do_reset();
    bus.data = 32'h00000A05; bus.load = 1'b1; step(); bus.load = 1'b0;
    while (e < 48) step();
    bus.blank_lz = 1'b1;
    while (e < 96) begin
      step();
      ex = exp_out(e, 32'h00000A05, 8'hFF, 8'h00, 1'b1);
      n_chk++;
      if ({bus.an, bus.a2g, bus.dp} !== ex) begin
        n_fail++;
        $display("FAIL lz_a05 e=%0d: got %h, want %h", e, {bus.an, bus.a2g, bus.dp}, ex);
      end
    end
    do_reset();
    while (e < 48) begin
      step();
      ex = (e <= 4) ? {8'hFE, 7'h40, 1'b1} : {8'hFF, 7'h7F, 1'b1};
      n_chk++;
      if ({bus.an, bus.a2g, bus.dp} !== ex) begin
        n_fail++;
        $display("FAIL lz_zero e=%0d: got %h, want %h", e, {bus.an, bus.a2g, bus.dp}, ex);
      end
    end
    bus.blank_lz = 1'b0;
  endtask
  task automatic test_masks();
    logic [15:0] ex;
    int dp_low = 0;
    do_reset();
    bus.en_mask = 8'h0F; bus.dp_mask = 8'h04;
    while (e < 96) begin
      step();
      ex = exp_out(e, 32'h0, 8'h0F, 8'h04, 1'b0);
      if (bus.dp === 1'b0) dp_low++;
      n_chk++;
      if ({bus.an, bus.a2g, bus.dp} !== ex || bus.frame_done !== (e % 48 == 0)) begin
        n_fail++;
        $display("FAIL masks e=%0d: got %h/%b, want %h/%b", e, {bus.an, bus.a2g, bus.dp}, bus.frame_done, ex, e % 48 == 0);
      end
    end
    n_chk++;
    if (dp_low != 8) begin
      n_fail++;
      $display("FAIL dp_count: got %0d, want 8", dp_low);
    end
    bus.en_mask = 8'hFF; bus.dp_mask = 8'h00;
  endtask
  task automatic test_reset_mid_frame();
    logic [15:0] ex;
    do_reset();
    bus.data = 32'h12345678; bus.load = 1'b1; step(); bus.load = 1'b0;
    while (e < 32) step();
    n_chk++;
    if (bus.an !== 8'hDF) begin
      n_fail++;
      $display("FAIL mid_digit5: got an=%h, want DF", bus.an);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.an, bus.a2g, bus.dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      n_fail++;
      $display("FAIL async_reset: got %h, want FFFF", {bus.an, bus.a2g, bus.dp});
    end
    @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    while (e < 96) begin
      step();
      ex = exp_out(e, 32'h0, 8'hFF, 8'h00, 1'b0);
      n_chk++;
      if ({bus.an, bus.a2g, bus.dp} !== ex) begin
        n_fail++;
        $display("FAIL post_reset e=%0d: got %h, want %h", e, {bus.an, bus.a2g, bus.dp}, ex);
      end
    end
  endtask
  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_leading_zero();
    test_masks();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
